konami1_opcode_encoder: RTL and testbench



---
 rtl/konami1_opcode_encoder.sv | 127 ++++++++++++
 tb/tb_konami1_opcode_encoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/konami1_opcode_encoder.sv
// Streaming KONAMI-1 opcode encoder: plaintext bytes in over valid/ready, keyed bytes out
// through a 2-entry FIFO onto an acknowledged program-memory write port.
`timescale 1ns/1ps

module konami1_opcode_encoder #(
  parameter logic [15:0] CPU_BASE = 16'h0000
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic        finish,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_op,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic [15:0] count,
  output logic        wrapped
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t      state;
  logic [15:0] offset;
  logic [15:0] fifoAddr [2];
  logic [7:0]  fifoData [2];
  logic        wrPtr;
  logic        rdPtr;
  logic [1:0]  level;

  logic [15:0] keyAddr;
  logic [7:0]  key;
  logic [7:0]  encByte;
  logic        accept;
  logic        pop;

  // Key depends on the CPU-visible address, not the raw memory offset.
  always_comb begin
    keyAddr = offset + CPU_BASE;
    key     = {keyAddr[1], 1'b0, ~keyAddr[1], 1'b0, keyAddr[3], 1'b0, ~keyAddr[3], 1'b0};
    encByte = in_op ? (in_data ^ key) : in_data;
  end

  always_comb begin
    in_ready = (state == RUN) && (level != 2'd2);
    accept   = in_valid && in_ready;
    mem_we   = (level != 2'd0);
    pop      = mem_ack && mem_we;
    mem_addr = fifoAddr[rdPtr];
    mem_data = fifoData[rdPtr];
    busy     = (state != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state       <= IDLE;
      offset      <= '0;
      fifoAddr[0] <= '0;
      fifoAddr[1] <= '0;
      fifoData[0] <= '0;
      fifoData[1] <= '0;
      wrPtr       <= 1'b0;
      rdPtr       <= 1'b0;
      level       <= '0;
      count       <= '0;
      done        <= 1'b0;
      wrapped     <= 1'b0;
    end else begin
      if (accept) begin
        fifoAddr[wrPtr] <= offset;
        fifoData[wrPtr] <= encByte;
        wrPtr           <= ~wrPtr;
        offset          <= offset + 16'd1;
      end

      if (pop) begin
        rdPtr <= ~rdPtr;
        count <= count + 16'd1;
      end

      case ({accept, pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase

      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            offset  <= start_addr;
            count   <= '0;
            done    <= 1'b0;
            wrapped <= 1'b0;
          end
        end
        RUN: begin
          // The byte at FFFF is kept; stopping here avoids a wrapped write to offset 0000.
          if (accept && (offset == 16'hFFFF)) begin
            wrapped <= 1'b1;
            state   <= DRAIN;
          end else if (finish) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((level == 2'd0) || ((level == 2'd1) && pop)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_konami1_opcode_encoder.sv
// Directed self-checking bench for konami1_opcode_encoder; a second instance covers a
// non-zero CPU_BASE on the same stimulus.
`timescale 1ns/1ps

module tb_konami1_opcode_encoder;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic        start;
  logic [15:0] start_addr;
  logic        finish;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_op;
  logic        mem_ack;

  logic        in_ready,  in_ready2;
  logic [15:0] mem_addr,  mem_addr2;
  logic [7:0]  mem_data,  mem_data2;
  logic        mem_we,    mem_we2;
  logic        busy,      busy2;
  logic        done,      done2;
  logic [15:0] count,     count2;
  logic        wrapped,   wrapped2;

  int assertCount = 0;
  int failCount   = 0;

  logic [15:0] wrAddr [$];
  logic [7:0]  wrData [$];
  logic [15:0] wrAddr2 [$];
  logic [7:0]  wrData2 [$];

  logic [7:0]  byteData [16];
  logic        byteOp   [16];
  logic [15:0] expAddr  [16];
  logic [7:0]  expData  [16];

  always #5 CLK = ~CLK;

  konami1_opcode_encoder #(.CPU_BASE(16'h0000)) dut (
    .CLK(CLK), .nRESET(nRESET), .start(start), .start_addr(start_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ack(mem_ack),
    .busy(busy), .done(done), .count(count), .wrapped(wrapped)
  );

  konami1_opcode_encoder #(.CPU_BASE(16'h8002)) dutBase (
    .CLK(CLK), .nRESET(nRESET), .start(start), .start_addr(start_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_op(in_op),
    .mem_addr(mem_addr2), .mem_data(mem_data2), .mem_we(mem_we2), .mem_ack(mem_ack),
    .busy(busy2), .done(done2), .count(count2), .wrapped(wrapped2)
  );

  // Writes are logged mid-cycle, where the handshake inputs are stable.
  always @(negedge CLK) begin
    if (mem_we && mem_ack) begin
      wrAddr.push_back(mem_addr);
      wrData.push_back(mem_data);
    end
    if (mem_we2 && mem_ack) begin
      wrAddr2.push_back(mem_addr2);
      wrData2.push_back(mem_data2);
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearLogs();
    wrAddr.delete();
    wrData.delete();
    wrAddr2.delete();
    wrData2.delete();
  endtask

  task automatic startRun(input logic [15:0] addr);
    clearLogs();
    start_addr = addr;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Presents byteData/byteOp[first..first+n-1] and returns once all are accepted.
  task automatic feed(input int first, input int n);
    int idx   = first;
    int guard = 0;
    logic took;
    while ((idx < first + n) && (guard < 200)) begin
      in_valid = 1'b1;
      in_data  = byteData[idx];
      in_op    = byteOp[idx];
      took     = in_ready;
      tick();
      if (took) idx++;
      guard++;
    end
    in_valid = 1'b0;
    checkVal("feedTimeout", idx, first + n);
  endtask

  task automatic finishAndWait();
    int guard = 0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    while (!done && (guard < 50)) begin
      tick();
      guard++;
    end
    checkVal("doneTimeout", done, 1'b1);
  endtask

  task automatic checkLog(input string tag, input int n);
    checkVal({tag, "Len"}, wrAddr.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < wrAddr.size()) begin
        checkVal($sformatf("%sAddr%0d", tag, i), wrAddr[i], expAddr[i]);
        checkVal($sformatf("%sData%0d", tag, i), wrData[i], expData[i]);
      end
    end
  endtask

  initial begin
    int   accepts;
    logic took;

    nRESET = 1'b0; start = 1'b0; start_addr = '0; finish = 1'b0;
    in_valid = 1'b0; in_data = '0; in_op = 1'b0; mem_ack = 1'b0;
    tick();
    tick();
    nRESET = 1'b1;

    checkVal("rstInReady", in_ready, 1'b0);
    checkVal("rstMemWe",   mem_we,   1'b0);
    checkVal("rstMemAddr", mem_addr, 16'h0000);
    checkVal("rstMemData", mem_data, 8'h00);
    checkVal("rstBusy",    busy,     1'b0);
    checkVal("rstDone",    done,     1'b0);
    checkVal("rstCount",   count,    16'h0000);
    checkVal("rstWrapped", wrapped,  1'b0);

    // Encode: eleven zero opcodes from offset 0.
    for (int i = 0; i < 11; i++) begin
      byteData[i] = 8'h00;
      byteOp[i]   = 1'b1;
      expAddr[i]  = 16'(i);
    end
    expData[0] = 8'h22; expData[1] = 8'h22; expData[2]  = 8'h82; expData[3] = 8'h82;
    expData[4] = 8'h22; expData[5] = 8'h22; expData[6]  = 8'h82; expData[7] = 8'h82;
    expData[8] = 8'h28; expData[9] = 8'h28; expData[10] = 8'h88;
    mem_ack = 1'b1;
    startRun(16'h0000);
    checkVal("startInReady", in_ready, 1'b1);
    checkVal("startBusy",    busy,     1'b1);
    feed(0, 11);
    finishAndWait();
    checkLog("enc", 11);
    checkVal("encCount", count, 16'd11);
    checkVal("encBusy",  busy,  1'b0);

    // Same run seen through CPU_BASE=8002.
    checkVal("baseLen", wrAddr2.size(), 11);
    if (wrAddr2.size() >= 3) begin
      checkVal("baseAddr0", wrAddr2[0], 16'h0000);
      checkVal("baseData0", wrData2[0], 8'h82);
      checkVal("baseData1", wrData2[1], 8'h82);
      checkVal("baseData2", wrData2[2], 8'h22);
    end

    // Pass-through of data bytes.
    for (int i = 0; i < 4; i++) begin
      byteData[i] = 8'hA5;
      byteOp[i]   = 1'b0;
      expAddr[i]  = 16'(i);
      expData[i]  = 8'hA5;
    end
    startRun(16'h0000);
    feed(0, 4);
    finishAndWait();
    checkLog("pass", 4);

    // Mixed opcode/operand bytes starting at offset 000A.
    byteData[0] = 8'hFF; byteOp[0] = 1'b1; expData[0] = 8'h77;
    byteData[1] = 8'h11; byteOp[1] = 1'b0; expData[1] = 8'h11;
    byteData[2] = 8'h3C; byteOp[2] = 1'b1; expData[2] = 8'h14;
    byteData[3] = 8'h77; byteOp[3] = 1'b0; expData[3] = 8'h77;
    for (int i = 0; i < 4; i++) expAddr[i] = 16'h000A + 16'(i);
    startRun(16'h000A);
    feed(0, 4);
    finishAndWait();
    checkLog("mix", 4);

    // Backpressure: no ack for ten cycles.
    for (int i = 0; i < 4; i++) begin
      byteData[i] = 8'h10 + 8'(i);
      byteOp[i]   = 1'b0;
      expAddr[i]  = 16'h0100 + 16'(i);
      expData[i]  = 8'h10 + 8'(i);
    end
    mem_ack = 1'b0;
    startRun(16'h0100);
    accepts = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = byteData[accepts];
      in_op    = 1'b0;
      took     = in_ready;
      tick();
      if (took) accepts++;
    end
    checkVal("bpAccepts", accepts,  2);
    checkVal("bpInReady", in_ready, 1'b0);
    checkVal("bpMemWe",   mem_we,   1'b1);
    checkVal("bpHeadAdr", mem_addr, 16'h0100);
    checkVal("bpHeadDat", mem_data, 8'h10);
    mem_ack = 1'b1;
    feed(2, 2);
    finishAndWait();
    checkLog("bp", 4);
    checkVal("bpCount", count, 16'd4);

    // Wrap at the top of the offset range.
    byteData[0] = 8'hA1; byteData[1] = 8'hA2; byteData[2] = 8'hA3;
    for (int i = 0; i < 3; i++) byteOp[i] = 1'b0;
    expAddr[0] = 16'hFFFE; expData[0] = 8'hA1;
    expAddr[1] = 16'hFFFF; expData[1] = 8'hA2;
    startRun(16'hFFFE);
    accepts = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = byteData[accepts];
      took     = in_ready;
      tick();
      if (took) accepts++;
    end
    in_valid = 1'b0;
    checkVal("wrapAccepts", accepts,  2);
    checkVal("wrapInReady", in_ready, 1'b0);
    checkVal("wrapFlag",    wrapped,  1'b1);
    checkVal("wrapDone",    done,     1'b1);
    checkVal("wrapCount",   count,    16'd2);
    checkLog("wrap", 2);

    // Reset while two entries are pending.
    for (int i = 0; i < 4; i++) begin
      byteData[i] = 8'h40 + 8'(i);
      byteOp[i]   = 1'b0;
    end
    startRun(16'h0000);
    feed(0, 3);
    mem_ack = 1'b0;
    feed(3, 1);
    checkVal("preRstCount", count,    16'd2);
    checkVal("preRstMemWe", mem_we,   1'b1);
    checkVal("preRstReady", in_ready, 1'b0);
    nRESET = 1'b0;
    tick();
    nRESET = 1'b1;
    checkVal("midRstMemWe", mem_we,   1'b0);
    checkVal("midRstBusy",  busy,     1'b0);
    checkVal("midRstCount", count,    16'd0);
    checkVal("midRstReady", in_ready, 1'b0);
    checkVal("midRstDone",  done,     1'b0);

    byteData[0] = 8'h00; byteOp[0] = 1'b1;
    expAddr[0]  = 16'h0004; expData[0] = 8'h22;
    mem_ack = 1'b1;
    startRun(16'h0004);
    feed(0, 1);
    finishAndWait();
    checkLog("fresh", 1);
    checkVal("freshCount", count, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL globalTimeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
